hub75_receiver: RTL and testbench

Receiving end of the HUB75 interface that `matrix_scan` drives. It oversamples the panel-side signals (pixel clock, latch, output enable, row address, RGB) on the system clock and rebuilds each latched 64-pixel line. It then streams that line, tagged with row, bit-plane and column, to a frame-capture write port, and measures each output-enable pulse. It sits in the verification/loopback path (panel emulator, scan self-test), not in the panel drive path.

---
 rtl/hub75_receiver.sv | 148 ++++++++++++++
 tb/tb_hub75_receiver.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_receiver.sv
// HUB75 loopback receiver: oversamples panel signals, rebuilds each latched line
// into a double buffer, streams it as tagged write beats and measures OE pulses.
module hub75_receiver #(
  parameter int COLUMNS  = 64,
  parameter int PLANES   = 6,
  parameter int OE_WIDTH = 12
) (
  input  logic                       clk_in,
  input  logic                       reset_n,
  input  logic                       hub_clk,
  input  logic                       hub_lat,
  input  logic                       hub_oe,
  input  logic [3:0]                 hub_addr,
  input  logic [5:0]                 hub_rgb,
  output logic                       wr_valid,
  input  logic                       wr_ready,
  output logic [3:0]                 wr_row,
  output logic [2:0]                 wr_plane,
  output logic [$clog2(COLUMNS)-1:0] wr_col,
  output logic [5:0]                 wr_data,
  output logic [OE_WIDTH-1:0]        oe_width,
  output logic [2:0]                 oe_plane,
  output logic                       oe_done,
  output logic                       short_line,
  output logic                       overrun,
  output logic                       commit_overflow
);
  localparam int CW = $clog2(COLUMNS);
  localparam logic [CW:0]   FULL = (CW+1)'(COLUMNS);
  localparam logic [CW-1:0] LAST = CW'(COLUMNS - 1);

  // Write-beat handshake: a beat moves on any clk_in edge where wr_valid && wr_ready;
  // while wr_valid is high and wr_ready low, wr_row/wr_plane/wr_col/wr_data hold.
  typedef enum logic [1:0] {IDLE, START, SEND} state_t;
  state_t state, state_nx;

  logic [12:0] s1, s2;
  logic [2:0]  s3;
  logic        clk_rise, lat_rise, oe_rise, oe_fall;
  logic [3:0]  addr;
  logic [5:0]  rgb;

  assign clk_rise = s2[12] & ~s3[2];
  assign lat_rise = s2[11] & ~s3[1];
  assign oe_rise  = s2[10] & ~s3[0];
  assign oe_fall  = ~s2[10] & s3[0];
  assign addr     = s2[9:6];
  assign rgb      = s2[5:0];

  logic [CW:0]         pix_n, n_eff;
  logic                pix_store, pix_over;
  logic                shift_sel, rd_sel;
  logic [CW-1:0]       wr_idx;
  logic [2:0]          plane, plane_nx;
  logic [3:0]          prev_row;
  logic [OE_WIDTH-1:0] oe_cnt;
  logic                commit_start;
  logic [5:0]          line_buf [2][COLUMNS];

  assign pix_store    = clk_rise && (pix_n != FULL);
  assign pix_over     = clk_rise && (pix_n == FULL);
  assign n_eff        = pix_n + {{CW{1'b0}}, pix_store};
  assign wr_idx       = LAST - pix_n[CW-1:0];
  assign rd_sel       = ~shift_sel;
  assign commit_start = lat_rise && (state == IDLE);
  assign plane_nx     = (addr != prev_row || plane == 3'd0) ? 3'(PLANES - 1) : plane - 3'd1;

  // A pixel arriving in the latch cycle lands in the outgoing buffer before the swap.
  always_ff @(posedge clk_in) begin
    if (pix_store) line_buf[shift_sel][wr_idx] <= rgb;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (lat_rise) state_nx = START;
      START:   state_nx = SEND;
      SEND:    if (wr_ready && wr_col == LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    wr_valid = (state == SEND);
    wr_data  = '0;
    if (wr_valid) wr_data = line_buf[rd_sel][wr_col];
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      s1              <= '0;
      s2              <= '0;
      s3              <= '0;
      pix_n           <= '0;
      shift_sel       <= 1'b0;
      plane           <= '0;
      prev_row        <= '0;
      wr_row          <= '0;
      wr_plane        <= '0;
      wr_col          <= '0;
      oe_cnt          <= '0;
      oe_width        <= '0;
      oe_plane        <= '0;
      oe_done         <= 1'b0;
      short_line      <= 1'b0;
      overrun         <= 1'b0;
      commit_overflow <= 1'b0;
    end else begin
      s1 <= {hub_clk, hub_lat, hub_oe, hub_addr, hub_rgb};
      s2 <= s1;
      s3 <= s2[12:10];

      if (lat_rise)       pix_n <= '0;
      else if (pix_store) pix_n <= pix_n + 1'b1;
      if (pix_over) overrun <= 1'b1;

      if (lat_rise) begin
        if (n_eff < FULL) short_line <= 1'b1;
        plane    <= plane_nx;
        prev_row <= addr;
        if (state != IDLE) commit_overflow <= 1'b1;
      end

      if (commit_start) begin
        shift_sel <= ~shift_sel;
        wr_row    <= addr;
        wr_plane  <= plane_nx;
        wr_col    <= '0;
      end else if (state == SEND && wr_ready) begin
        wr_col <= wr_col + 1'b1;
      end

      // The rising-edge cycle is itself a high cycle, so the count restarts at 1.
      if (oe_rise)                       oe_cnt <= OE_WIDTH'(1);
      else if (s2[10] && oe_cnt != '1)   oe_cnt <= oe_cnt + 1'b1;
      oe_done <= oe_fall;
      if (oe_fall) begin
        oe_width <= oe_cnt;
        oe_plane <= plane;
      end
    end
  end
endmodule

// File: tb/tb_hub75_receiver.sv
// Randomized scoreboard bench for hub75_receiver: a line/plane model predicts the
// write beats, OE measurements and sticky flags.
module tb_hub75_receiver;
  localparam int COLUMNS = 64;
  localparam int PLANES  = 6;
  localparam int OEW     = 12;

  logic clk_in = 0, reset_n = 0;
  logic hub_clk = 0, hub_lat = 0, hub_oe = 0;
  logic [3:0] hub_addr = 0;
  logic [5:0] hub_rgb = 0;
  logic wr_valid, wr_ready = 1;
  logic [3:0] wr_row;
  logic [2:0] wr_plane;
  logic [5:0] wr_col, wr_data;
  logic [OEW-1:0] oe_width;
  logic [2:0] oe_plane;
  logic oe_done, short_line, overrun, commit_overflow;

  hub75_receiver #(.COLUMNS(COLUMNS), .PLANES(PLANES), .OE_WIDTH(OEW)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .hub_clk(hub_clk), .hub_lat(hub_lat),
    .hub_oe(hub_oe), .hub_addr(hub_addr), .hub_rgb(hub_rgb), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_row(wr_row), .wr_plane(wr_plane), .wr_col(wr_col),
    .wr_data(wr_data), .oe_width(oe_width), .oe_plane(oe_plane), .oe_done(oe_done),
    .short_line(short_line), .overrun(overrun), .commit_overflow(commit_overflow));

  // clock / reset
  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [3:0] row;
    logic [2:0] plane;
    logic [5:0] col;
    logic [5:0] data;
    logic       chk;
  } beat_t;

  beat_t exp_q[$];
  logic [OEW+2:0] oe_q[$];
  int checks = 0, failures = 0;
  int ready_mode = 0;
  int oe_pulses = 0;

  // reference model state
  logic [5:0] line_pix[$];
  logic [3:0] m_prev_row;
  int  m_run;
  bit  m_first;
  logic [2:0] m_plane;
  bit  exp_short, exp_over, exp_ovf;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic model_reset();
    line_pix.delete();
    exp_q.delete();
    oe_q.delete();
    m_prev_row = 0; m_run = 0; m_first = 1; m_plane = 0;
    exp_short = 0; exp_over = 0; exp_ovf = 0;
  endtask

  task automatic model_latch(input logic [3:0] a);
    beat_t b;
    int idx;
    if (m_first || a != m_prev_row) m_run = 0;
    else m_run++;
    m_first = 0;
    m_prev_row = a;
    m_plane = 3'(PLANES - 1 - (m_run % PLANES));
    if (line_pix.size() < COLUMNS) exp_short = 1;
    if (line_pix.size() > COLUMNS) exp_over = 1;
    if (exp_q.size() != 0) exp_ovf = 1;
    else begin
      for (int c = 0; c < COLUMNS; c++) begin
        idx = COLUMNS - 1 - c;
        b.row = a; b.plane = m_plane; b.col = 6'(c);
        b.chk = (idx < line_pix.size());
        b.data = b.chk ? line_pix[idx] : 6'd0;
        exp_q.push_back(b);
      end
    end
    line_pix.delete();
  endtask

  // driver tasks
  task automatic pixel(input logic [5:0] v);
    hub_rgb = v;
    tick(2);
    hub_clk = 1;
    tick(2);
    hub_clk = 0;
  endtask

  task automatic send_line(input int n, input bit rnd);
    logic [5:0] v;
    for (int i = 0; i < n; i++) begin
      v = rnd ? 6'($urandom_range(0, 63)) : 6'(i % 64);
      pixel(v);
      line_pix.push_back(v);
    end
  endtask

  task automatic latch(input logic [3:0] a);
    hub_addr = a;
    tick(1);
    model_latch(a);
    hub_lat = 1;
    tick(2);
    hub_lat = 0;
    tick(1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin tick(1); t++; end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    tick(2);
  endtask

  task automatic oe_pulse(input int n);
    hub_oe = 1;
    tick(n);
    hub_oe = 0;
    tick(8);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_short_line"}, short_line, exp_short);
    check({tag, "_overrun"}, overrun, exp_over);
    check({tag, "_commit_overflow"}, commit_overflow, exp_ovf);
  endtask

  // ready driver
  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      case (ready_mode)
        0:       wr_ready = 1;
        1:       wr_ready = 1'($urandom_range(0, 1));
        default: wr_ready = 0;
      endcase
    end
  end

  // scoreboard monitor
  initial begin
    beat_t held, got, e;
    bit stall = 0;
    logic [OEW+2:0] oe_e;
    forever begin
      @(negedge clk_in);
      if (!reset_n) begin stall = 0; continue; end
      if (oe_done) begin
        oe_pulses++;
        if (oe_q.size() == 0) check("unexpected_oe_done", 1, 0);
        else begin
          oe_e = oe_q.pop_front();
          check("oe_width", oe_width, oe_e[OEW-1:0]);
          check("oe_plane", oe_plane, oe_e[OEW+2:OEW]);
        end
      end
      if (wr_valid) begin
        got.row = wr_row; got.plane = wr_plane; got.col = wr_col;
        got.data = wr_data; got.chk = 1'b1;
        if (stall) check("stall_stable", got, held);
        if (wr_ready) begin
          stall = 0;
          if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("beat_row", got.row, e.row);
            check("beat_plane", got.plane, e.plane);
            check("beat_col", got.col, e.col);
            if (e.chk) check("beat_data", got.data, e.data);
          end
        end else begin
          stall = 1;
          held = got;
        end
      end else stall = 0;
    end
  end

  // main sequence
  initial begin
    int t;
    model_reset();
    tick(5);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_row", wr_row, 0);
    check("rst_wr_plane", wr_plane, 0);
    check("rst_wr_col", wr_col, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_oe_width", oe_width, 0);
    check("rst_oe_plane", oe_plane, 0);
    check("rst_oe_done", oe_done, 0);
    check_flags("rst");
    reset_n = 1;
    tick(2);

    // nominal line: rgb = pixel index, so column c carries 63-c
    send_line(64, 0);
    latch(3);
    wait_drain();
    check_flags("nominal");

    // plane sequencing with random backpressure
    ready_mode = 1;
    for (int k = 0; k < 5; k++) begin send_line(64, 1); wait_drain(); latch(3); end
    send_line(64, 1); wait_drain(); latch(4);
    for (int k = 0; k < 7; k++) begin send_line(64, 1); wait_drain(); latch(3); end
    wait_drain();
    check_flags("planes");

    send_line(63, 1); latch(2); wait_drain();
    check_flags("short");
    send_line(65, 1); latch(6); wait_drain();
    check_flags("overrun");

    // second latch while the first line is stalled
    ready_mode = 2;
    send_line(64, 1); latch(7);
    tick(10);
    latch(7);
    tick(5);
    check_flags("overflow");
    ready_mode = 0;
    wait_drain();

    // OE measurement after the plane-3 latch on a new row
    for (int k = 0; k < 3; k++) begin latch(5); wait_drain(); end
    oe_q.push_back({m_plane, 12'd92});
    oe_pulse(92);
    oe_q.push_back({m_plane, 12'd4095});
    oe_pulse(5000);
    check("oe_pulse_count", oe_pulses, 2);
    check("oe_queue_left", oe_q.size(), 0);

    // reset during commit
    ready_mode = 1;
    send_line(64, 1); latch(9);
    t = 0;
    while (!wr_valid && t < 200) begin tick(1); t++; end
    check("commit_started", wr_valid, 1);
    #2 reset_n = 0;
    #1 check("async_reset_valid", wr_valid, 0);
    model_reset();
    tick(3);
    reset_n = 1;
    tick(10);
    check("post_reset_valid", wr_valid, 0);
    check("post_reset_oe_width", oe_width, 0);
    check_flags("post_reset");

    ready_mode = 0;
    send_line(64, 0); latch(1); wait_drain();
    check_flags("final");
    check("exp_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
